lz77_token_packer: RTL and testbench

LZ77_TOKEN_PACKER -- requirements
Module: lz77_token_packer

---
 rtl/lz77_token_packer_pkg.sv | 28 ++
 rtl/lz77_token_fifo.sv | 59 +++++
 rtl/lz77_token_packer.sv | 171 +++++++++++++++++
 tb/tb_lz77_token_packer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lz77_token_packer_pkg.sv
// Shared definitions for the LZ77 token packer.
// - pack_state_e: packer FSM states (RUN accepts tokens, FLUSH drains the stream tail)
// - match_token_bits / literal_token_bits: token widths from the field widths
// - acc_bits: accumulator width, one output word plus the widest token
package lz77_token_packer_pkg;

    typedef enum logic [0:0] {
        StRun   = 1'b0,
        StFlush = 1'b1
    } pack_state_e;

    // {next_symbol, length, position, 1'b1}
    function automatic int unsigned match_token_bits(int unsigned data_w, int unsigned cnt_w,
                                                     int unsigned pos_w);
        return data_w + cnt_w + pos_w + 1;
    endfunction

    // {next_symbol, 1'b0}
    function automatic int unsigned literal_token_bits(int unsigned data_w);
        return data_w + 1;
    endfunction

    // Fill stays below out_w before an append, so out_w + widest token never overflows.
    function automatic int unsigned acc_bits(int unsigned out_w, int unsigned tok_w);
        return out_w + tok_w;
    endfunction

endpackage

// File: rtl/lz77_token_fifo.sv
// Single-clock synchronous token FIFO with occupancy count.
// Ports: clk, rst_n (async active-low), wr_en/wr_data (write dropped when full),
// rd_en (pop, ignored when empty), rd_data (head entry, valid while !empty),
// full, empty, count (0..2^DEPTH_LOG).
module lz77_token_fifo #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH_LOG = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 rd_en,
    output logic [WIDTH-1:0]     rd_data,
    output logic                 full,
    output logic                 empty,
    output logic [DEPTH_LOG:0]   count
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0]   FULL_COUNT = (DEPTH_LOG + 1)'(DEPTH);
    localparam logic [DEPTH_LOG:0]   CNT_ONE    = (DEPTH_LOG + 1)'(1);
    localparam logic [DEPTH_LOG-1:0] PTR_ONE    = DEPTH_LOG'(1);

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [DEPTH_LOG-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG:0]   count_q;
    logic                 do_wr, do_rd;

    assign full    = (count_q == FULL_COUNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // Full is judged before any same-cycle pop, so a write to a full FIFO is always dropped.
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_rd) rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/lz77_token_packer.sv
// Packs LZ77 literal/match tokens into an LSB-first bitstream of OUT_WIDTH-bit words.
// Ports: clk, rst_n (async active-low); in_valid + in_match_* / in_last_symbol token input with
// in_ready (FIFO has room for the filter pipeline); out_data/out_valid_bits/out_last with
// out_valid/out_ready handshake; overflow (sticky, a token was dropped on a full FIFO).
module lz77_token_packer
    import lz77_token_packer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH           = 8,
    parameter int unsigned DICTIONARY_DEPTH_LOG = 16,
    parameter int unsigned CNT_WIDTH            = 9,
    parameter int unsigned OUT_WIDTH            = 32,
    parameter int unsigned FIFO_DEPTH_LOG       = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic [DICTIONARY_DEPTH_LOG:0] in_match_position,
    input  logic [CNT_WIDTH-1:0]          in_match_length,
    input  logic [DATA_WIDTH-1:0]         in_match_next_symbol,
    input  logic                          in_match_valid,
    input  logic                          in_last_symbol,
    output logic                          in_ready,
    output logic [OUT_WIDTH-1:0]          out_data,
    output logic [5:0]                    out_valid_bits,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last,
    output logic                          overflow
);

    localparam int unsigned POS_W   = DICTIONARY_DEPTH_LOG + 1;
    localparam int unsigned TOK_W   = match_token_bits(DATA_WIDTH, CNT_WIDTH, POS_W);
    localparam int unsigned LIT_W   = literal_token_bits(DATA_WIDTH);
    localparam int unsigned ACC_W   = acc_bits(OUT_WIDTH, TOK_W);
    localparam int unsigned FILL_W  = $clog2(ACC_W + 1);
    localparam int unsigned ENTRY_W = POS_W + CNT_WIDTH + DATA_WIDTH + 2;
    localparam int unsigned FDEPTH  = 1 << FIFO_DEPTH_LOG;

    localparam logic [FILL_W-1:0]       OUT_FILL   = FILL_W'(OUT_WIDTH);
    localparam logic [FILL_W-1:0]       MATCH_LEN  = FILL_W'(TOK_W);
    localparam logic [FILL_W-1:0]       LIT_LEN    = FILL_W'(LIT_W);
    localparam logic [5:0]              VB_FULL    = 6'(OUT_WIDTH);
    localparam logic [FIFO_DEPTH_LOG:0] READY_OCC  = (FIFO_DEPTH_LOG + 1)'(FDEPTH - 3);

    // FIFO entry: {last, match_valid, next_symbol, length, position}
    logic [ENTRY_W-1:0]        fifo_wr_data, fifo_rd_data;
    logic                      fifo_full, fifo_empty, pop;
    logic [FIFO_DEPTH_LOG:0]   fifo_count;

    logic                      tok_last, tok_is_match;
    logic [DATA_WIDTH-1:0]     tok_sym;
    logic [CNT_WIDTH-1:0]      tok_len;
    logic [POS_W-1:0]          tok_pos;
    logic [TOK_W-1:0]          pop_token;
    logic [FILL_W-1:0]         pop_len;

    pack_state_e               state_q, state_d;
    logic [ACC_W-1:0]          acc_q, acc_d;
    logic [FILL_W-1:0]         fill_q, fill_d;
    logic [OUT_WIDTH-1:0]      out_data_q, out_data_d;
    logic [5:0]                out_valid_bits_q, out_valid_bits_d;
    logic                      out_valid_q, out_valid_d;
    logic                      out_last_q, out_last_d;
    logic                      overflow_q;
    logic                      slot_free;

    assign fifo_wr_data = {in_last_symbol, in_match_valid, in_match_next_symbol,
                           in_match_length, in_match_position};

    lz77_token_fifo #(
        .WIDTH     (ENTRY_W),
        .DEPTH_LOG (FIFO_DEPTH_LOG)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (in_valid),
        .wr_data (fifo_wr_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Two spare entries absorb tokens already in flight in the upstream filter.
    assign in_ready = (fifo_count <= READY_OCC);

    assign {tok_last, tok_is_match, tok_sym, tok_len, tok_pos} = fifo_rd_data;

    always_comb begin
        if (tok_is_match) begin
            pop_token = {tok_sym, tok_len, tok_pos, 1'b1};
            pop_len   = MATCH_LEN;
        end else begin
            pop_token = TOK_W'({tok_sym, 1'b0});
            pop_len   = LIT_LEN;
        end
    end

    always_comb begin
        state_d          = state_q;
        acc_d            = acc_q;
        fill_d           = fill_q;
        out_data_d       = out_data_q;
        out_valid_bits_d = out_valid_bits_q;
        out_valid_d      = out_valid_q;
        out_last_d       = out_last_q;
        pop              = 1'b0;
        slot_free        = !out_valid_q || out_ready;

        if (out_valid_q && out_ready) out_valid_d = 1'b0;

        // Emit first; pop then sees the post-emit fill.
        if (slot_free && (fill_q >= OUT_FILL)) begin
            out_data_d       = acc_q[OUT_WIDTH-1:0];
            out_valid_bits_d = VB_FULL;
            out_valid_d      = 1'b1;
            acc_d            = acc_q >> OUT_WIDTH;
            fill_d           = fill_q - OUT_FILL;
            out_last_d       = (state_q == StFlush) && (fill_d == '0);
            if (out_last_d) state_d = StRun;
        end else if (slot_free && (state_q == StFlush) && (fill_q != '0)) begin
            // Bits above fill are already zero, so the residue goes out zero-padded.
            out_data_d       = acc_q[OUT_WIDTH-1:0];
            out_valid_bits_d = 6'(fill_q);
            out_valid_d      = 1'b1;
            out_last_d       = 1'b1;
            acc_d            = '0;
            fill_d           = '0;
            state_d          = StRun;
        end else if ((state_q == StFlush) && (fill_q == '0)) begin
            state_d = StRun;
        end

        if ((state_q == StRun) && !fifo_empty && (fill_d < OUT_FILL)) begin
            pop    = 1'b1;
            acc_d  = acc_d | (ACC_W'(pop_token) << fill_d);
            fill_d = fill_d + pop_len;
            if (tok_last) state_d = StFlush;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= StRun;
            acc_q            <= '0;
            fill_q           <= '0;
            out_data_q       <= '0;
            out_valid_bits_q <= '0;
            out_valid_q      <= 1'b0;
            out_last_q       <= 1'b0;
            overflow_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            acc_q            <= acc_d;
            fill_q           <= fill_d;
            out_data_q       <= out_data_d;
            out_valid_bits_q <= out_valid_bits_d;
            out_valid_q      <= out_valid_d;
            out_last_q       <= out_last_d;
            if (in_valid && fifo_full) overflow_q <= 1'b1;
        end
    end

    assign out_data       = out_data_q;
    assign out_valid_bits = out_valid_bits_q;
    assign out_valid      = out_valid_q;
    assign out_last       = out_last_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_lz77_token_packer.sv
module tb_lz77_token_packer;

    localparam int DW = 8;
    localparam int PW = 17;
    localparam int CW = 9;
    localparam int OW = 32;

    typedef struct {
        logic          m;
        logic [PW-1:0] pos;
        logic [CW-1:0] len;
        logic [DW-1:0] sym;
        logic          last;
    } tok_t;

    typedef struct {
        logic [OW-1:0] data;
        logic [5:0]    bits;
        logic          last;
    } word_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid;
    logic [PW-1:0] in_match_position;
    logic [CW-1:0] in_match_length;
    logic [DW-1:0] in_match_next_symbol;
    logic          in_match_valid;
    logic          in_last_symbol;
    logic          in_ready;
    logic [OW-1:0] out_data;
    logic [5:0]    out_valid_bits;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          overflow;

    lz77_token_packer dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .in_valid             (in_valid),
        .in_match_position    (in_match_position),
        .in_match_length      (in_match_length),
        .in_match_next_symbol (in_match_next_symbol),
        .in_match_valid       (in_match_valid),
        .in_last_symbol       (in_last_symbol),
        .in_ready             (in_ready),
        .out_data             (out_data),
        .out_valid_bits       (out_valid_bits),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .out_last             (out_last),
        .overflow             (overflow)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    word_t exp_q[$];
    logic [127:0] macc;
    int mfill;
    logic rnd_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic push_exp(input logic [31:0] d, input logic [5:0] b, input logic l);
        word_t w;
        w.data = d;
        w.bits = b;
        w.last = l;
        exp_q.push_back(w);
    endtask

    // Reference bitstream: append whole tokens, cut 32-bit words, keep a full word back
    // until it is known whether the stream ends on it.
    task automatic model_add(input tok_t t);
        logic [127:0] v;
        int w;
        if (t.m) begin
            v = 128'(t.sym);
            v = (v << CW) | 128'(t.len);
            v = (v << PW) | 128'(t.pos);
            v = (v << 1) | 128'd1;
            w = DW + CW + PW + 1;
        end else begin
            v = 128'(t.sym) << 1;
            w = DW + 1;
        end
        macc = macc | (v << mfill);
        mfill = mfill + w;
        while (mfill > OW) begin
            push_exp(macc[31:0], 6'd32, 1'b0);
            macc = macc >> OW;
            mfill = mfill - OW;
        end
        if (t.last) begin
            push_exp(macc[31:0], 6'(mfill), 1'b1);
            macc = '0;
            mfill = 0;
        end
    endtask

    task automatic send(input tok_t t, input bit to_model);
        int n;
        n = 0;
        while (!in_ready && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) check("in_ready_wait_timeout", 64'(in_ready), 64'd1);
        in_match_valid       = t.m;
        in_match_position    = t.pos;
        in_match_length      = t.len;
        in_match_next_symbol = t.sym;
        in_last_symbol       = t.last;
        in_valid             = 1'b1;
        if (to_model) model_add(t);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check({name, "_drain_left"}, 64'(exp_q.size()), 64'd0);
        repeat (6) @(posedge clk);
        #1;
        check({name, "_no_extra_word"}, 64'(out_valid), 64'd0);
    endtask

    always @(posedge clk) begin
        #1;
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    end

    // Output monitor: consume on handshake, check hold stability while stalled.
    logic  hold = 1'b0;
    word_t saved;
    word_t e;
    always @(negedge clk) begin
        if (!rst_n) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                n_vec++;
                if (out_valid !== 1'b1 || out_data !== saved.data ||
                    out_valid_bits !== saved.bits || out_last !== saved.last) begin
                    n_err++;
                    $display("FAIL hold_stable: got v=%0b d=%h b=%0d l=%0b want v=1 d=%h b=%0d l=%0b",
                             out_valid, out_data, out_valid_bits, out_last,
                             saved.data, saved.bits, saved.last);
                end
            end
            hold = 1'b0;
            if (out_valid === 1'b1) begin
                if (out_ready === 1'b1) begin
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_word: got d=%h b=%0d l=%0b want no word",
                                 out_data, out_valid_bits, out_last);
                    end else begin
                        e = exp_q.pop_front();
                        if (out_data !== e.data || out_valid_bits !== e.bits ||
                            out_last !== e.last) begin
                            n_err++;
                            $display("FAIL word: got d=%h b=%0d l=%0b want d=%h b=%0d l=%0b",
                                     out_data, out_valid_bits, out_last, e.data, e.bits, e.last);
                        end
                    end
                end else begin
                    saved.data = out_data;
                    saved.bits = out_valid_bits;
                    saved.last = out_last;
                    hold = 1'b1;
                end
            end
        end
    end

    initial begin
        tok_t  lit_tab [5];
        word_t lit_exp [2];
        tok_t  t;
        int    occ;

        in_valid = 1'b0;
        in_match_position = '0;
        in_match_length = '0;
        in_match_next_symbol = '0;
        in_match_valid = 1'b0;
        in_last_symbol = 1'b0;
        out_ready = 1'b1;
        macc = '0;
        mfill = 0;

        lit_tab[0] = '{m: 1'b0, pos: '0, len: '0, sym: 8'h41, last: 1'b0};
        lit_tab[1] = '{m: 1'b0, pos: '0, len: '0, sym: 8'h42, last: 1'b0};
        lit_tab[2] = '{m: 1'b0, pos: '0, len: '0, sym: 8'h43, last: 1'b0};
        lit_tab[3] = '{m: 1'b0, pos: '0, len: '0, sym: 8'h44, last: 1'b0};
        lit_tab[4] = '{m: 1'b0, pos: '0, len: '0, sym: 8'h45, last: 1'b1};
        lit_exp[0] = '{data: 32'h4219_0882, bits: 6'd32, last: 1'b0};
        lit_exp[1] = '{data: 32'h0000_08A4, bits: 6'd13, last: 1'b1};

        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        #5 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Five literals: 36 bits in the first four, residue of 13 bits with the fifth.
        for (int i = 0; i < 2; i++) exp_q.push_back(lit_exp[i]);
        for (int i = 0; i < 5; i++) send(lit_tab[i], 1'b0);
        wait_drain("literals");

        // One 35-bit match token.
        push_exp(32'h0810_000B, 6'd32, 1'b0);
        push_exp(32'h0000_0003, 6'd3, 1'b1);
        t = '{m: 1'b1, pos: 17'd5, len: 9'd4, sym: 8'h61, last: 1'b1};
        send(t, 1'b0);
        wait_drain("one_match");

        // 2 matches + 10 literals = 160 bits, a whole number of words.
        for (int i = 0; i < 12; i++) begin
            t.m    = (i == 3 || i == 8);
            t.pos  = 17'($urandom);
            t.len  = 9'($urandom);
            t.sym  = 8'($urandom);
            t.last = (i == 11);
            send(t, 1'b1);
        end
        wait_drain("exact_words");

        // Random streams under random backpressure.
        rnd_ready = 1'b1;
        for (int s = 0; s < 4; s++) begin
            int n;
            n = $urandom_range(1, 14);
            for (int i = 0; i < n; i++) begin
                t.m    = 1'($urandom_range(0, 1));
                t.pos  = 17'($urandom);
                t.len  = 9'($urandom);
                t.sym  = 8'($urandom);
                t.last = (i == n - 1);
                send(t, 1'b1);
            end
        end
        wait_drain("random");
        rnd_ready = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Stall the output and flood the FIFO: two tokens sink into the accumulator,
        // the rest pile up until the FIFO holds 16 and further writes are dropped.
        out_ready = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            in_match_valid       = 1'b1;
            in_match_position    = 17'(k);
            in_match_length      = 9'd3;
            in_match_next_symbol = 8'(k);
            in_last_symbol       = 1'b0;
            in_valid             = 1'b1;
            @(posedge clk);
            #1;
            occ = (k <= 3) ? 1 : ((k - 2 > 16) ? 16 : k - 2);
            check($sformatf("flood_in_ready_%0d", k), 64'(in_ready), 64'(occ <= 13));
            check($sformatf("flood_overflow_%0d", k), 64'(overflow), 64'(k >= 19));
        end
        in_valid = 1'b0;
        check("flood_out_valid", 64'(out_valid), 64'd1);

        // Asynchronous reset while a word is held on the output.
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 64'(out_valid), 64'd0);
        check("async_rst_overflow", 64'(overflow), 64'd0);
        check("async_rst_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        macc = '0;
        mfill = 0;
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) send(lit_tab[i], 1'b1);
        wait_drain("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
